avalon_arg_host: RTL and testbench

//  Avalon-MM host-side command sequencer: the initiator that drives the accelerator's
//  io_S_AVALON_* slave port (argIn writes, start write, status poll, argOut reads).

---
 rtl/avalon_arg_host_pkg.sv | 34 +++
 rtl/avalon_arg_host_if.sv | 35 +++
 rtl/avalon_arg_host_wait_ctr.sv | 26 ++
 rtl/avalon_arg_host.sv | 149 ++++++++++++++
 tb/tb_avalon_arg_host.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/avalon_arg_host_pkg.sv
// Shared types and helpers for the Avalon-MM host command sequencer.
package avalon_arg_host_pkg;

  typedef enum logic [1:0] {
    OP_NOP  = 2'd0,
    OP_WR   = 2'd1,
    OP_RD   = 2'd2,
    OP_POLL = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    StIdle,
    StWr,
    StRdReq,
    StRdWait,
    StGap,
    StResp
  } state_e;

  typedef struct packed {
    logic valid;
    logic timeout;
  } rsp_flags_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Bits needed to hold 0..max_val, never less than one.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/avalon_arg_host_if.sv
// Command/response stream plus Avalon-MM initiator signals of the host sequencer.
interface avalon_arg_host_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_data;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_timeout;
  logic              busy;
  logic [ADDR_W-1:0] avm_address;
  logic              avm_chipselect;
  logic              avm_write;
  logic              avm_read;
  logic [DATA_W-1:0] avm_writedata;
  logic [DATA_W-1:0] avm_readdata;

  // Sequencer side.
  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_data, avm_readdata,
    output cmd_ready, rsp_valid, rsp_data, rsp_timeout, busy,
    output avm_address, avm_chipselect, avm_write, avm_read, avm_writedata
  );

  // Controller / bus-agent side.
  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_data, avm_readdata,
    input  cmd_ready, rsp_valid, rsp_data, rsp_timeout, busy,
    input  avm_address, avm_chipselect, avm_write, avm_read, avm_writedata
  );
endinterface

// File: rtl/avalon_arg_host_wait_ctr.sv
// Loadable down-counter with zero flag; used for both read-latency and poll-gap waits.
module avalon_arg_host_wait_ctr #(
  parameter int unsigned W = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/avalon_arg_host.sv
// Avalon-MM host command sequencer: turns NOP/WRITE/READ/POLL commands into bus strobes
// with fixed-latency read capture and returns one response per command.
module avalon_arg_host
  import avalon_arg_host_pkg::*;
#(
  parameter int unsigned ADDR_W       = 8,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned POLL_GAP     = 4,
  parameter int unsigned POLL_TIMEOUT = 1024
) (
  input logic              clock,
  input logic              reset,
  avalon_arg_host_if.slave bus
);

  localparam int unsigned WaitW = cnt_width(max_u(READ_LATENCY, POLL_GAP));
  localparam int unsigned PollW = $clog2(POLL_TIMEOUT + 1);
  localparam logic [WaitW-1:0] RdLoad  = WaitW'(READ_LATENCY - 1);
  localparam logic [WaitW-1:0] GapLoad = WaitW'((POLL_GAP == 0) ? 0 : POLL_GAP - 1);

  state_e            state_q, state_d;
  op_e               op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [PollW-1:0]  poll_cnt_q, poll_cnt_d;
  logic              accept, hit;
  logic              wait_load, wait_zero;
  logic [WaitW-1:0]  wait_load_val;
  logic              timeout_d;
  logic [DATA_W-1:0] rsp_data_d;

  logic              cmd_ready_q, busy_q, cs_q, wr_q, rd_q;
  rsp_flags_t        rsp_flags_q;
  logic [DATA_W-1:0] rsp_data_q;

  avalon_arg_host_wait_ctr #(
    .W (WaitW)
  ) u_wait_ctr (
    .clk_i      (clock),
    .rst_i      (reset),
    .load_i     (wait_load),
    .load_val_i (wait_load_val),
    .zero_o     (wait_zero)
  );

  assign accept = bus.cmd_valid && cmd_ready_q;
  // A zero mask means "just sample once": the first read always completes.
  assign hit    = ((bus.avm_readdata & data_q) != '0) || (data_q == '0);

  always_comb begin
    state_d       = state_q;
    poll_cnt_d    = poll_cnt_q;
    wait_load     = 1'b0;
    wait_load_val = '0;
    timeout_d     = 1'b0;
    rsp_data_d    = '0;
    case (state_q)
      StIdle: begin
        if (accept) begin
          poll_cnt_d = '0;
          case (op_e'(bus.cmd_op))
            OP_WR:          state_d = StWr;
            OP_RD, OP_POLL: state_d = StRdReq;
            default:        state_d = StResp;
          endcase
        end
      end
      StWr: state_d = StResp;
      StRdReq: begin
        state_d       = StRdWait;
        wait_load     = 1'b1;
        wait_load_val = RdLoad;
      end
      StRdWait: begin
        if (wait_zero) begin
          if ((op_q == OP_POLL) && !hit) begin
            poll_cnt_d = poll_cnt_q + 1'b1;
            if (poll_cnt_d == PollW'(POLL_TIMEOUT)) begin
              state_d    = StResp;
              timeout_d  = 1'b1;
              rsp_data_d = bus.avm_readdata;
            end else if (POLL_GAP == 0) begin
              state_d = StRdReq;
            end else begin
              state_d       = StGap;
              wait_load     = 1'b1;
              wait_load_val = GapLoad;
            end
          end else begin
            state_d    = StResp;
            rsp_data_d = bus.avm_readdata;
          end
        end
      end
      StGap: begin
        if (wait_zero) state_d = StRdReq;
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are registered from the next state so strobes line up with the state they belong to.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      op_q        <= OP_NOP;
      addr_q      <= '0;
      data_q      <= '0;
      poll_cnt_q  <= '0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      cs_q        <= 1'b0;
      wr_q        <= 1'b0;
      rd_q        <= 1'b0;
      rsp_flags_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      poll_cnt_q <= poll_cnt_d;
      if (accept) begin
        op_q   <= op_e'(bus.cmd_op);
        addr_q <= bus.cmd_addr;
        data_q <= bus.cmd_data;
      end
      cmd_ready_q         <= (state_d == StIdle);
      busy_q              <= (state_d != StIdle);
      cs_q                <= (state_d == StWr) || (state_d == StRdReq);
      wr_q                <= (state_d == StWr);
      rd_q                <= (state_d == StRdReq);
      rsp_flags_q.valid   <= (state_d == StResp);
      rsp_flags_q.timeout <= timeout_d;
      rsp_data_q          <= rsp_data_d;
    end
  end

  assign bus.cmd_ready      = cmd_ready_q;
  assign bus.busy           = busy_q;
  assign bus.rsp_valid      = rsp_flags_q.valid;
  assign bus.rsp_timeout    = rsp_flags_q.timeout;
  assign bus.rsp_data       = rsp_data_q;
  assign bus.avm_address    = addr_q;
  assign bus.avm_writedata  = data_q;
  assign bus.avm_chipselect = cs_q;
  assign bus.avm_write      = wr_q;
  assign bus.avm_read       = rd_q;

endmodule

// File: tb/tb_avalon_arg_host.sv
// Randomized bench: two sequencers (RL=1/GAP=4 and RL=3/GAP=0) against an Avalon slave model
// and a timing/data reference derived from the command rules.
module tb_avalon_arg_host;
  import avalon_arg_host_pkg::*;

  localparam int RL0 = 1, GAP0 = 4, RL1 = 3, GAP1 = 0, TIMEOUT = 8;
  localparam logic [7:0] STATUS = 8'h01;

  typedef struct packed {
    logic cmd_ready, busy, rsp_valid, rsp_timeout, cs, wr, rd;
    logic [7:0]  addr;
    logic [31:0] wdata, rsp_data;
  } obs_t;
  typedef struct packed {
    logic        valid;
    logic [1:0]  op;
    logic [7:0]  addr;
    logic [31:0] data;
  } drv_t;
  typedef struct {int inst; int cyc; logic [31:0] data; logic to;} rsp_e;
  typedef struct {int inst; int cyc; logic wr; logic rd; logic [7:0] addr; logic [31:0] wdata;} stb_e;

  logic clock = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_vec = 0, n_err = 0;

  obs_t        obs [2];
  drv_t        drv [2];
  logic [31:0] mem [2][256];
  logic [31:0] ref_mem [2][256];
  logic [31:0] pipe [2][4];
  int          status_reads [2] = '{0, 0};
  int          status_base [2] = '{0, 0};
  int          status_pre [2] = '{0, 0};
  logic [31:0] pre_val [2], hit_val [2];
  int          last_rsp [2] = '{0, 0};
  bit          last_hold [2] = '{0, 0};
  logic [7:0]  pool [8] = '{8'h00, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
  rsp_e        rsp_q [$];
  stb_e        stb_q [$];

  avalon_arg_host_if #(.ADDR_W(8), .DATA_W(32)) bus0 ();
  avalon_arg_host_if #(.ADDR_W(8), .DATA_W(32)) bus1 ();

  avalon_arg_host #(
    .ADDR_W(8), .DATA_W(32), .READ_LATENCY(RL0), .POLL_GAP(GAP0), .POLL_TIMEOUT(TIMEOUT)
  ) u_dut0 (
    .clock (clock),
    .reset (reset),
    .bus   (bus0)
  );

  avalon_arg_host #(
    .ADDR_W(8), .DATA_W(32), .READ_LATENCY(RL1), .POLL_GAP(GAP1), .POLL_TIMEOUT(TIMEOUT)
  ) u_dut1 (
    .clock (clock),
    .reset (reset),
    .bus   (bus1)
  );

  assign bus0.cmd_valid    = drv[0].valid;
  assign bus0.cmd_op       = drv[0].op;
  assign bus0.cmd_addr     = drv[0].addr;
  assign bus0.cmd_data     = drv[0].data;
  assign bus0.avm_readdata = pipe[0][RL0-1];
  assign bus1.cmd_valid    = drv[1].valid;
  assign bus1.cmd_op       = drv[1].op;
  assign bus1.cmd_addr     = drv[1].addr;
  assign bus1.cmd_data     = drv[1].data;
  assign bus1.avm_readdata = pipe[1][RL1-1];

  assign obs[0] = {bus0.cmd_ready, bus0.busy, bus0.rsp_valid, bus0.rsp_timeout,
                   bus0.avm_chipselect, bus0.avm_write, bus0.avm_read, bus0.avm_address,
                   bus0.avm_writedata, bus0.rsp_data};
  assign obs[1] = {bus1.cmd_ready, bus1.busy, bus1.rsp_valid, bus1.rsp_timeout,
                   bus1.avm_chipselect, bus1.avm_write, bus1.avm_read, bus1.avm_address,
                   bus1.avm_writedata, bus1.rsp_data};

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic int rl(input int i);
    return (i == 0) ? RL0 : RL1;
  endfunction

  function automatic int gap(input int i);
    return (i == 0) ? GAP0 : GAP1;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  // Slave model: registers plus a status register that stays clear for status_pre reads.
  // Outside the latency window readdata carries noise, so a mistimed capture shows up.
  always @(posedge clock) begin
    for (int i = 0; i < 2; i++) begin
      for (int s = 3; s > 0; s--) pipe[i][s] <= pipe[i][s-1];
      if (obs[i].wr) mem[i][obs[i].addr] <= obs[i].wdata;
      if (obs[i].rd) begin
        if (obs[i].addr == STATUS) begin
          pipe[i][0] <= (status_reads[i] - status_base[i] < status_pre[i]) ? pre_val[i]
                                                                            : hit_val[i];
          status_reads[i] <= status_reads[i] + 1;
        end else begin
          pipe[i][0] <= mem[i][obs[i].addr];
        end
      end else begin
        pipe[i][0] <= $urandom;
      end
    end
  end

  always @(negedge clock) begin
    for (int i = 0; i < 2; i++) begin
      if (obs[i].rsp_valid)
        rsp_q.push_back('{inst: i, cyc: cyc, data: obs[i].rsp_data, to: obs[i].rsp_timeout});
      if (obs[i].cs || obs[i].wr || obs[i].rd) begin
        stb_q.push_back('{inst: i, cyc: cyc, wr: obs[i].wr, rd: obs[i].rd,
                          addr: obs[i].addr, wdata: obs[i].wdata});
        check_eq($sformatf("u%0d cs_vs_strobes", i), obs[i].cs, obs[i].wr | obs[i].rd);
        check_eq($sformatf("u%0d wr_rd_exclusive", i), obs[i].wr & obs[i].rd, 0);
      end
    end
  end

  task automatic setup_poll(input int i, input int pre, input logic [31:0] mask);
    status_base[i] = status_reads[i];
    status_pre[i]  = pre;
    pre_val[i]     = $urandom & ~mask;
    hit_val[i]     = $urandom | mask;
  endtask

  task automatic run_cmd(input int i, input logic [1:0] op, input logic [7:0] addr,
                         input logic [31:0] data, input bit hold);
    int n, k, per, exp_rsp, exp_stb;
    logic [31:0] exp_data;
    logic exp_to;
    bit got;
    string t;
    rsp_e r;
    stb_e s;
    t = $sformatf("u%0d op%0d a%0h", i, op, addr);
    drv[i] = '{valid: 1'b1, op: op, addr: addr, data: data};
    got = 0;
    for (int w = 0; w < 100; w++) begin
      if (obs[i].cmd_ready) begin
        got = 1;
        break;
      end
      step();
    end
    check_eq({t, " accept"}, got, 1);
    if (!got) return;
    n = cyc;
    if (last_hold[i]) check_eq({t, " accept_cyc"}, n, last_rsp[i] + 1);
    step();
    // Fields change while busy to show they are ignored; valid stays up for held runs.
    drv[i] = '{valid: hold, op: 2'($urandom), addr: 8'($urandom), data: $urandom};

    per = 1 + rl(i) + gap(i);
    exp_data = '0;
    exp_to = 1'b0;
    k = 0;
    case (op)
      OP_NOP: exp_rsp = n + 1;
      OP_WR: begin
        exp_rsp = n + 2;
        ref_mem[i][addr] = data;
      end
      OP_RD: begin
        k = 1;
        exp_rsp = n + 2 + rl(i);
        exp_data = ref_mem[i][addr];
      end
      default: begin
        if (data == '0) begin
          k = 1;
          exp_data = (status_pre[i] > 0) ? pre_val[i] : hit_val[i];
        end else if (status_pre[i] < TIMEOUT) begin
          k = status_pre[i] + 1;
          exp_data = hit_val[i];
        end else begin
          k = TIMEOUT;
          exp_data = pre_val[i];
          exp_to = 1'b1;
        end
        exp_rsp = n + 2 + rl(i) + (k - 1) * per;
      end
    endcase
    exp_stb = (op == OP_WR) ? 1 : k;

    for (int w = 0; w < 400 && rsp_q.size() == 0; w++) step();
    check_eq({t, " rsp_seen"}, rsp_q.size() > 0, 1);
    if (rsp_q.size() == 0) return;
    r = rsp_q.pop_front();
    check_eq({t, " rsp_inst"}, r.inst, i);
    check_eq({t, " rsp_cycle"}, r.cyc - n, exp_rsp - n);
    check_eq({t, " rsp_data"}, r.data, exp_data);
    check_eq({t, " rsp_timeout"}, r.to, exp_to);
    last_rsp[i] = r.cyc;
    last_hold[i] = hold;

    check_eq({t, " strobe_count"}, stb_q.size(), exp_stb);
    for (int j = 0; j < stb_q.size(); j++) begin
      s = stb_q[j];
      check_eq({t, " stb_inst"}, s.inst, i);
      check_eq({t, " stb_cycle"}, s.cyc - n, 1 + j * per);
      check_eq({t, " stb_write"}, s.wr, op == OP_WR);
      check_eq({t, " stb_read"}, s.rd, op != OP_WR);
      check_eq({t, " stb_addr"}, s.addr, addr);
      if (op == OP_WR) check_eq({t, " stb_wdata"}, s.wdata, data);
    end
    stb_q.delete();
  endtask

  task automatic run_suite(input int i);
    logic [1:0]  op;
    logic [7:0]  addr;
    logic [31:0] data;
    bit          hold;
    for (int a = 0; a < 8; a++) run_cmd(i, OP_WR, pool[a], $urandom, 0);
    run_cmd(i, OP_WR, 8'h02, 32'h4, 0);
    run_cmd(i, OP_WR, 8'h04, 32'h1234, 0);
    run_cmd(i, OP_WR, 8'h00, 32'h1, 0);
    run_cmd(i, OP_RD, 8'h04, 32'h0, 0);
    setup_poll(i, 3, 32'h1);
    run_cmd(i, OP_POLL, STATUS, 32'h1, 0);
    setup_poll(i, 100, 32'h1);
    pre_val[i] = '0;
    run_cmd(i, OP_POLL, STATUS, 32'h1, 0);
    // cmd_valid held high across a chain of commands.
    run_cmd(i, OP_NOP, 8'h00, 32'h0, 1);
    run_cmd(i, OP_WR, 8'h08, $urandom, 1);
    run_cmd(i, OP_RD, 8'h08, 32'h0, 1);
    setup_poll(i, 2, 32'h0);
    run_cmd(i, OP_POLL, STATUS, 32'h0, 0);
    for (int c = 0; c < 25; c++) begin
      op = 2'($urandom_range(0, 3));
      hold = (c < 24) ? 1'($urandom_range(0, 1)) : 1'b0;
      addr = pool[$urandom_range(0, 7)];
      data = $urandom;
      if (op == OP_NOP) addr = 8'($urandom);
      if (op == OP_POLL) begin
        addr = STATUS;
        data = ($urandom_range(0, 3) == 0) ? 32'h0 : (32'h1 << $urandom_range(0, 31));
        setup_poll(i, $urandom_range(0, 10), data);
      end
      run_cmd(i, op, addr, data, hold);
    end
  endtask

  task automatic reset_mid_poll();
    int n;
    setup_poll(0, 100, 32'h1);
    drv[0] = '{valid: 1'b1, op: OP_POLL, addr: STATUS, data: 32'h1};
    for (int w = 0; w < 20 && !obs[0].cmd_ready; w++) step();
    n = cyc;
    step();
    drv[0].valid = 1'b0;
    // Gap cycles for the first poll read with RL=1 are n+3..n+6.
    for (int w = 0; w < 20 && cyc < n + 4; w++) step();
    check_eq("rst_mid busy_before", obs[0].busy, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_eq("rst_mid strobes", {obs[0].cs, obs[0].wr, obs[0].rd}, 3'b000);
    check_eq("rst_mid busy", obs[0].busy, 0);
    check_eq("rst_mid rsp_valid", obs[0].rsp_valid, 0);
    check_eq("rst_mid cmd_ready", obs[0].cmd_ready, 1);
    stb_q.delete();
    repeat (30) step();
    check_eq("rst_mid no_rsp", rsp_q.size(), 0);
    check_eq("rst_mid no_strobes", stb_q.size(), 0);
    last_hold[0] = 1'b0;
    run_cmd(0, OP_RD, 8'h04, 32'h0, 0);
  endtask

  initial begin
    reset = 1'b1;
    drv[0] = '0;
    drv[1] = '0;
    repeat (3) step();
    reset = 1'b0;
    step();
    for (int i = 0; i < 2; i++) begin
      check_eq($sformatf("u%0d reset cmd_ready", i), obs[i].cmd_ready, 1);
      check_eq($sformatf("u%0d reset busy", i), obs[i].busy, 0);
      check_eq($sformatf("u%0d reset strobes", i), {obs[i].cs, obs[i].wr, obs[i].rd}, 3'b000);
      check_eq($sformatf("u%0d reset rsp", i), {obs[i].rsp_valid, obs[i].rsp_timeout}, 2'b00);
      check_eq($sformatf("u%0d reset rsp_data", i), obs[i].rsp_data, 0);
      check_eq($sformatf("u%0d reset addr", i), obs[i].addr, 0);
    end
    run_suite(0);
    run_suite(1);
    reset_mid_poll();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
